// File: rtl/mem_sram_ctl_if.sv
// Core-to-SRAM request/response bus: single outstanding request, one-cycle ready pulse.
interface mem_sram_ctl_if;
  logic [31:0] mem_addr;
  logic        mem_read_valid;
  logic        mem_write_valid;
  logic [1:0]  mem_width;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        mem_ready;
  logic        mem_error;

  modport master (
    output mem_addr, mem_read_valid, mem_write_valid, mem_width, mem_write_data,
    input  mem_read_data, mem_ready, mem_error
  );

  modport slave (
    input  mem_addr, mem_read_valid, mem_write_valid, mem_width, mem_write_data,
    output mem_read_data, mem_ready, mem_error
  );
endinterface

// File: rtl/mem_sram_ctl.sv
// On-chip SRAM controller: byte/half/word access with WAIT_CYCLES wait states and lane masking.
// Optional macro MEM_ALIGN_CHECK_EN flags misaligned/reserved accesses instead of force-aligning them.
module mem_sram_ctl #(
  parameter int    ADDR_BITS   = 12,
  parameter int    WAIT_CYCLES = 2,
  parameter string INIT_FILE   = ""
) (
  input logic           clk,
  input logic           rst,
  mem_sram_ctl_if.slave bus
);
  localparam int WORDS = 1 << (ADDR_BITS - 2);

  typedef enum logic [1:0] {IDLE, BUSY, RESP, DRAIN} state_t;

  state_t               state, state_nxt;
  logic [31:0]          mem [WORDS];
  logic [ADDR_BITS-1:0] addr_q;
  logic [1:0]           width_q;
  logic [31:0]          wdata_q;
  logic                 wr_q;
  logic [3:0]           cnt;
  logic                 ready_q, err_q;
  logic [31:0]          rdata_q;
  logic                 req;
  logic [1:0]           lo, wd;
  logic                 err;
  logic [3:0]           be;
  logic [31:0]          wrep, rword, rfmt;
  logic                 unused_addr;

  assign req         = bus.mem_read_valid | bus.mem_write_valid;
  assign unused_addr = ^bus.mem_addr[31:ADDR_BITS];
  assign rword       = mem[addr_q[ADDR_BITS-1:2]];

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // DRAIN holds off re-acceptance until the requester drops valid, so a held valid is served once.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = (WAIT_CYCLES == 0) ? RESP : BUSY;
      BUSY:    if (cnt == 4'd0) state_nxt = RESP;
      RESP:    state_nxt = DRAIN;
      DRAIN:   if (!req) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Effective width/offset after alignment policy, lane enables and replicated write data.
  always_comb begin
    lo  = addr_q[1:0];
    wd  = width_q;
    err = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    err = (width_q == 2'd1 && addr_q[0]) ||
          (width_q == 2'd2 && addr_q[1:0] != 2'b00) ||
          (width_q == 2'd3);
`else
    if (wd == 2'd3) wd = 2'd2;
    if (wd == 2'd1) lo[0] = 1'b0;
    if (wd == 2'd2) lo = 2'b00;
`endif
    be   = 4'hF;
    wrep = wdata_q;
    rfmt = rword;
    case (wd)
      2'd0: begin
        be   = 4'b0001 << lo;
        wrep = {4{wdata_q[7:0]}};
        rfmt = {24'h0, rword[{lo, 3'b000} +: 8]};
      end
      2'd1: begin
        be   = lo[1] ? 4'b1100 : 4'b0011;
        wrep = {2{wdata_q[15:0]}};
        rfmt = {16'h0, rword[{lo[1], 4'b0000} +: 16]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
      cnt     <= 4'd0;
    end else begin
      ready_q <= 1'b0;
      if (state == IDLE && req) begin
        addr_q  <= bus.mem_addr[ADDR_BITS-1:0];
        width_q <= bus.mem_width;
        wdata_q <= bus.mem_write_data;
        wr_q    <= bus.mem_write_valid;
        if (WAIT_CYCLES > 0) cnt <= 4'(WAIT_CYCLES - 1);
      end else if (state == BUSY && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (state == RESP) begin
        ready_q <= 1'b1;
        err_q   <= err;
        if (!wr_q) rdata_q <= err ? 32'h0 : rfmt;
      end
    end
  end

  // Array update shares the completion edge; a reset before it aborts the write.
  always_ff @(posedge clk) begin
    if (rst && state == RESP && wr_q && !err)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[addr_q[ADDR_BITS-1:2]][8*i +: 8] <= wrep[8*i +: 8];
  end

  assign bus.mem_ready     = ready_q;
  assign bus.mem_error     = err_q;
  assign bus.mem_read_data = rdata_q;
endmodule
